mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM stage of a 64-bit in-order pipeline together with the MEM/WB pipeline
// register. Aligned loads and stores are sent to a memory port that
// handshakes with an acknowledge. While the memory is busy, a stall freezes
// the upstream stages. A wait counter aborts an access that is never
// acknowledged. Misaligned accesses are dropped and reported through a
// sticky error flag.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   EXMEM_*             : EX/MEM pipeline register contents (inputs)
//   mem_req/we/addr/wdata, mem_rdata/ack : memory request/response port
//   stall               : holds PC, IF/ID, ID/EX and EX/MEM when high
//   PCSrc, branch_target: taken-branch redirect to fetch
//   mem_err             : sticky; misaligned access or access timeout
//   MEMWB_*             : MEM/WB pipeline register contents (outputs)
// -----------------------------------------------------------------------------
module mem_wb_stage (
   input  logic        clk,
   input  logic        reset,
   // EX/MEM register
   input  logic [63:0] EXMEM_Result,
   input  logic [63:0] EXMEM_ReadData2,
   input  logic [63:0] EXMEM_out,
   input  logic [4:0]  EXMEM_inst2,
   input  logic        EXMEM_ZERO,
   input  logic        EXMEM_Branch,
   input  logic        EXMEM_MemRead,
   input  logic        EXMEM_MemWrite,
   input  logic        EXMEM_MemtoReg,
   input  logic        EXMEM_Regwrite,
   // memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   // pipeline control
   output logic        stall,
   output logic        PCSrc,
   output logic [63:0] branch_target,
   output logic        mem_err,
   // MEM/WB register
   output logic [63:0] MEMWB_ReadData,
   output logic [63:0] MEMWB_Result,
   output logic [4:0]  MEMWB_inst2,
   output logic        MEMWB_MemtoReg,
   output logic        MEMWB_Regwrite
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;

   // Access parameters captured on entry to WAIT, so upstream changes are
   // irrelevant while the access is outstanding.
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [4:0]  rd_q, rd_d;
   logic        m2r_q, m2r_d;
   logic        rw_q, rw_d;

   logic        err_q, err_d;

   logic [63:0] mwb_rdata_q, mwb_rdata_d;
   logic [63:0] mwb_result_q, mwb_result_d;
   logic [4:0]  mwb_rd_q, mwb_rd_d;
   logic        mwb_m2r_q, mwb_m2r_d;
   logic        mwb_rw_q, mwb_rw_d;

   logic        mem_op;
   logic        aligned;
   logic        pending;
   logic        misalign;
   logic        timeout;
   logic        bubble;

   // Access classification
   always_comb begin
      mem_op   = EXMEM_MemRead | EXMEM_MemWrite;
      aligned  = (EXMEM_Result[2:0] == 3'b000);
      pending  = (state_q == S_IDLE) & mem_op & aligned;
      misalign = (state_q == S_IDLE) & mem_op & ~aligned;
      // The 16th unacknowledged WAIT cycle is the one seen with the counter at 15.
      timeout  = (state_q == S_WAIT) & ~mem_ack & (wcnt_q == 4'hF);
      stall    = pending | ((state_q == S_WAIT) & ~mem_ack & ~timeout);
   end

   // A branch is only taken once the stage is free to advance.
   always_comb begin
      PCSrc         = EXMEM_Branch & EXMEM_ZERO & ~stall;
      branch_target = EXMEM_out;
   end

   // Next-state, memory port and MEM/WB next values
   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      rd_d         = rd_q;
      m2r_d        = m2r_q;
      rw_d         = rw_q;
      err_d        = err_q;
      mwb_rdata_d  = mwb_rdata_q;
      mwb_result_d = mwb_result_q;
      mwb_rd_d     = mwb_rd_q;
      mwb_m2r_d    = mwb_m2r_q;
      mwb_rw_d     = mwb_rw_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      bubble       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pending) begin
               state_d = S_WAIT;
               wcnt_d  = 4'd0;
               addr_d  = EXMEM_Result;
               wdata_d = EXMEM_ReadData2;
               // Write wins when both read and write are flagged.
               we_d    = EXMEM_MemWrite;
               rd_d    = EXMEM_inst2;
               m2r_d   = EXMEM_MemtoReg;
               rw_d    = EXMEM_Regwrite;
               bubble  = 1'b1;
            end else if (misalign) begin
               err_d  = 1'b1;
               bubble = 1'b1;
            end else begin
               mwb_result_d = EXMEM_Result;
               mwb_rd_d     = EXMEM_inst2;
               mwb_m2r_d    = EXMEM_MemtoReg;
               mwb_rw_d     = EXMEM_Regwrite & (EXMEM_inst2 != 5'd0);
            end
         end
         S_WAIT: begin
            mem_req = 1'b1;
            mem_we  = we_q;
            if (mem_ack) begin
               state_d = S_IDLE;
               if (!we_q) begin
                  mwb_rdata_d = mem_rdata;
               end
               mwb_result_d = addr_q;
               mwb_rd_d     = rd_q;
               mwb_m2r_d    = m2r_q;
               mwb_rw_d     = rw_q & (rd_q != 5'd0);
            end else if (timeout) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               bubble  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
               bubble = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bubble) begin
         mwb_rdata_d  = 64'd0;
         mwb_result_d = 64'd0;
         mwb_rd_d     = 5'd0;
         mwb_m2r_d    = 1'b0;
         mwb_rw_d     = 1'b0;
      end
   end

   // State, latches and MEM/WB register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         wcnt_q       <= 4'd0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         we_q         <= 1'b0;
         rd_q         <= 5'd0;
         m2r_q        <= 1'b0;
         rw_q         <= 1'b0;
         err_q        <= 1'b0;
         mwb_rdata_q  <= 64'd0;
         mwb_result_q <= 64'd0;
         mwb_rd_q     <= 5'd0;
         mwb_m2r_q    <= 1'b0;
         mwb_rw_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         rd_q         <= rd_d;
         m2r_q        <= m2r_d;
         rw_q         <= rw_d;
         err_q        <= err_d;
         mwb_rdata_q  <= mwb_rdata_d;
         mwb_result_q <= mwb_result_d;
         mwb_rd_q     <= mwb_rd_d;
         mwb_m2r_q    <= mwb_m2r_d;
         mwb_rw_q     <= mwb_rw_d;
      end
   end

   always_comb begin
      mem_addr       = addr_q;
      mem_wdata      = wdata_q;
      mem_err        = err_q;
      MEMWB_ReadData = mwb_rdata_q;
      MEMWB_Result   = mwb_result_q;
      MEMWB_inst2    = mwb_rd_q;
      MEMWB_MemtoReg = mwb_m2r_q;
      MEMWB_Regwrite = mwb_rw_q;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage: reset, ALU pass-through, multi-wait load,
// zero-wait store, ack in IDLE, branch redirect, misaligned access, timeout
// and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;
   logic [63:0] EXMEM_Result;
   logic [63:0] EXMEM_ReadData2;
   logic [63:0] EXMEM_out;
   logic [4:0]  EXMEM_inst2;
   logic        EXMEM_ZERO;
   logic        EXMEM_Branch;
   logic        EXMEM_MemRead;
   logic        EXMEM_MemWrite;
   logic        EXMEM_MemtoReg;
   logic        EXMEM_Regwrite;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        PCSrc;
   logic [63:0] branch_target;
   logic        mem_err;
   logic [63:0] MEMWB_ReadData;
   logic [63:0] MEMWB_Result;
   logic [4:0]  MEMWB_inst2;
   logic        MEMWB_MemtoReg;
   logic        MEMWB_Regwrite;

   int tests;
   int fails;

   mem_wb_stage dut (
      .clk            (clk),
      .reset          (reset),
      .EXMEM_Result   (EXMEM_Result),
      .EXMEM_ReadData2(EXMEM_ReadData2),
      .EXMEM_out      (EXMEM_out),
      .EXMEM_inst2    (EXMEM_inst2),
      .EXMEM_ZERO     (EXMEM_ZERO),
      .EXMEM_Branch   (EXMEM_Branch),
      .EXMEM_MemRead  (EXMEM_MemRead),
      .EXMEM_MemWrite (EXMEM_MemWrite),
      .EXMEM_MemtoReg (EXMEM_MemtoReg),
      .EXMEM_Regwrite (EXMEM_Regwrite),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .stall          (stall),
      .PCSrc          (PCSrc),
      .branch_target  (branch_target),
      .mem_err        (mem_err),
      .MEMWB_ReadData (MEMWB_ReadData),
      .MEMWB_Result   (MEMWB_Result),
      .MEMWB_inst2    (MEMWB_inst2),
      .MEMWB_MemtoReg (MEMWB_MemtoReg),
      .MEMWB_Regwrite (MEMWB_Regwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nop_inputs;
      EXMEM_Result    = 64'd0;
      EXMEM_ReadData2 = 64'd0;
      EXMEM_out       = 64'd0;
      EXMEM_inst2     = 5'd0;
      EXMEM_ZERO      = 1'b0;
      EXMEM_Branch    = 1'b0;
      EXMEM_MemRead   = 1'b0;
      EXMEM_MemWrite  = 1'b0;
      EXMEM_MemtoReg  = 1'b0;
      EXMEM_Regwrite  = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 64'd0;
      nop_inputs();
      #13;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", mem_req); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", mem_we); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
      tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", mem_err); end
      tests++; if (MEMWB_Result !== 64'd0) begin fails++; $display("FAIL rst_result: got %h want 0", MEMWB_Result); end
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL rst_rw: got %b want 0", MEMWB_Regwrite); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_alu;
      EXMEM_Result   = 64'h2A;
      EXMEM_inst2    = 5'd5;
      EXMEM_Regwrite = 1'b1;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall_pre: got %b want 0", stall); end
      tick();
      tests++; if (MEMWB_Result !== 64'h2A) begin fails++; $display("FAIL alu_result: got %h want 2a", MEMWB_Result); end
      tests++; if (MEMWB_inst2 !== 5'd5) begin fails++; $display("FAIL alu_rd: got %0d want 5", MEMWB_inst2); end
      tests++; if (MEMWB_Regwrite !== 1'b1) begin fails++; $display("FAIL alu_rw: got %b want 1", MEMWB_Regwrite); end
      tests++; if (MEMWB_MemtoReg !== 1'b0) begin fails++; $display("FAIL alu_m2r: got %b want 0", MEMWB_MemtoReg); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall_post: got %b want 0", stall); end
      nop_inputs();
   endtask

   task automatic test_load;
      EXMEM_MemRead  = 1'b1;
      EXMEM_Result   = 64'h100;
      EXMEM_inst2    = 5'd7;
      EXMEM_MemtoReg = 1'b1;
      EXMEM_Regwrite = 1'b1;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ld_stall0: got %b want 1", stall); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ld_req_idle: got %b want 0", mem_req); end
      tick();
      tests++; if (MEMWB_Result !== 64'd0) begin fails++; $display("FAIL ld_bubble1: got %h want 0", MEMWB_Result); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ld_stall1: got %b want 1", stall); end
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL ld_req: got %b want 1", mem_req); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL ld_we: got %b want 0", mem_we); end
      tests++; if (mem_addr !== 64'h100) begin fails++; $display("FAIL ld_addr: got %h want 100", mem_addr); end
      // Upstream change while waiting must not reach the destination register.
      EXMEM_inst2 = 5'd9;
      tick();
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL ld_bubble2: got %b want 0", MEMWB_Regwrite); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ld_stall2: got %b want 1", stall); end
      tick();
      tests++; if (MEMWB_inst2 !== 5'd0) begin fails++; $display("FAIL ld_bubble3: got %0d want 0", MEMWB_inst2); end
      mem_ack   = 1'b1;
      mem_rdata = 64'hDEAD;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ld_stall_ack: got %b want 0", stall); end
      tick();
      mem_ack = 1'b0;
      nop_inputs();
      tests++; if (MEMWB_ReadData !== 64'hDEAD) begin fails++; $display("FAIL ld_rdata: got %h want dead", MEMWB_ReadData); end
      tests++; if (MEMWB_Result !== 64'h100) begin fails++; $display("FAIL ld_result: got %h want 100", MEMWB_Result); end
      tests++; if (MEMWB_inst2 !== 5'd7) begin fails++; $display("FAIL ld_rd: got %0d want 7", MEMWB_inst2); end
      tests++; if (MEMWB_MemtoReg !== 1'b1) begin fails++; $display("FAIL ld_m2r: got %b want 1", MEMWB_MemtoReg); end
      tests++; if (MEMWB_Regwrite !== 1'b1) begin fails++; $display("FAIL ld_rw: got %b want 1", MEMWB_Regwrite); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ld_req_done: got %b want 0", mem_req); end
   endtask

   task automatic test_store;
      EXMEM_MemWrite  = 1'b1;
      EXMEM_Result    = 64'h08;
      EXMEM_ReadData2 = 64'h55;
      EXMEM_inst2     = 5'd4;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL st_stall0: got %b want 1", stall); end
      tick();
      EXMEM_ReadData2 = 64'h99;
      mem_ack   = 1'b1;
      mem_rdata = 64'h1234;
      #1;
      tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL st_we: got %b want 1", mem_we); end
      tests++; if (mem_wdata !== 64'h55) begin fails++; $display("FAIL st_wdata: got %h want 55", mem_wdata); end
      tests++; if (mem_addr !== 64'h08) begin fails++; $display("FAIL st_addr: got %h want 8", mem_addr); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL st_stall_ack: got %b want 0", stall); end
      tick();
      mem_ack = 1'b0;
      nop_inputs();
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL st_rw: got %b want 0", MEMWB_Regwrite); end
      tests++; if (MEMWB_ReadData !== 64'd0) begin fails++; $display("FAIL st_rdata_kept: got %h want 0", MEMWB_ReadData); end
      tests++; if (MEMWB_Result !== 64'h08) begin fails++; $display("FAIL st_result: got %h want 8", MEMWB_Result); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL st_we_done: got %b want 0", mem_we); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL st_req_done: got %b want 0", mem_req); end
   endtask

   task automatic test_ack_idle;
      mem_ack   = 1'b1;
      mem_rdata = 64'hBEEF;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ackidle_stall: got %b want 0", stall); end
      tick();
      mem_ack = 1'b0;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ackidle_req: got %b want 0", mem_req); end
      tests++; if (MEMWB_ReadData !== 64'd0) begin fails++; $display("FAIL ackidle_rdata: got %h want 0", MEMWB_ReadData); end
   endtask

   task automatic test_branch;
      EXMEM_Branch = 1'b1;
      EXMEM_ZERO   = 1'b1;
      EXMEM_out    = 64'h40;
      #1;
      tests++; if (PCSrc !== 1'b1) begin fails++; $display("FAIL br_pcsrc: got %b want 1", PCSrc); end
      tests++; if (branch_target !== 64'h40) begin fails++; $display("FAIL br_target: got %h want 40", branch_target); end
      EXMEM_ZERO = 1'b0;
      #1;
      tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL br_nozero: got %b want 0", PCSrc); end
      EXMEM_ZERO    = 1'b1;
      EXMEM_MemRead = 1'b1;
      EXMEM_Result  = 64'h10;
      #1;
      tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL br_stall_pend: got %b want 0", PCSrc); end
      tick();
      tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL br_stall_wait: got %b want 0", PCSrc); end
      tests++; if (branch_target !== 64'h40) begin fails++; $display("FAIL br_target_wait: got %h want 40", branch_target); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      nop_inputs();
   endtask

   task automatic test_misaligned;
      EXMEM_Result   = 64'h33;
      EXMEM_inst2    = 5'd2;
      EXMEM_Regwrite = 1'b1;
      tick();
      EXMEM_MemRead  = 1'b1;
      EXMEM_Result   = 64'h103;
      EXMEM_inst2    = 5'd6;
      EXMEM_MemtoReg = 1'b1;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_stall: got %b want 0", stall); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_req: got %b want 0", mem_req); end
      tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL mis_err_pre: got %b want 0", mem_err); end
      tick();
      tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL mis_err: got %b want 1", mem_err); end
      tests++; if (MEMWB_Result !== 64'd0) begin fails++; $display("FAIL mis_bubble_res: got %h want 0", MEMWB_Result); end
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL mis_bubble_rw: got %b want 0", MEMWB_Regwrite); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_req_post: got %b want 0", mem_req); end
      nop_inputs();
      EXMEM_Result   = 64'h77;
      EXMEM_Regwrite = 1'b1;
      tick();
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL rd0_rw: got %b want 0", MEMWB_Regwrite); end
      tests++; if (MEMWB_Result !== 64'h77) begin fails++; $display("FAIL rd0_result: got %h want 77", MEMWB_Result); end
      tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", mem_err); end
      nop_inputs();
   endtask

   task automatic test_timeout;
      reset = 1'b0;
      #2;
      tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL to_err_reset: got %b want 0", mem_err); end
      @(negedge clk);
      reset = 1'b1;
      EXMEM_MemRead  = 1'b1;
      EXMEM_Result   = 64'h200;
      EXMEM_inst2    = 5'd3;
      EXMEM_Regwrite = 1'b1;
      tick();
      for (int i = 1; i <= 15; i++) begin
         tests++; if (stall !== 1'b1) begin fails++; $display("FAIL to_stall_c%0d: got %b want 1", i, stall); end
         tick();
      end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL to_stall_c16: got %b want 0", stall); end
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL to_req_c16: got %b want 1", mem_req); end
      nop_inputs();
      tick();
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL to_req_idle: got %b want 0", mem_req); end
      tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", mem_err); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL to_stall_idle: got %b want 0", stall); end
      tests++; if (MEMWB_Regwrite !== 1'b0) begin fails++; $display("FAIL to_bubble_rw: got %b want 0", MEMWB_Regwrite); end
      tests++; if (MEMWB_inst2 !== 5'd0) begin fails++; $display("FAIL to_bubble_rd: got %0d want 0", MEMWB_inst2); end
   endtask

   task automatic test_reset_mid_wait;
      EXMEM_MemWrite  = 1'b1;
      EXMEM_Result    = 64'h18;
      EXMEM_ReadData2 = 64'hAB;
      tick();
      tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL rw_we_pre: got %b want 1", mem_we); end
      nop_inputs();
      #2;
      reset = 1'b0;
      #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rw_req: got %b want 0", mem_req); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rw_we: got %b want 0", mem_we); end
      tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rw_err: got %b want 0", mem_err); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rw_stall: got %b want 0", stall); end
      tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL rw_pcsrc: got %b want 0", PCSrc); end
      tests++; if (MEMWB_Result !== 64'd0) begin fails++; $display("FAIL rw_result: got %h want 0", MEMWB_Result); end
      @(negedge clk);
      reset          = 1'b1;
      EXMEM_Result   = 64'h5;
      EXMEM_inst2    = 5'd1;
      EXMEM_Regwrite = 1'b1;
      tick();
      tests++; if (MEMWB_Result !== 64'h5) begin fails++; $display("FAIL rw_first_edge: got %h want 5", MEMWB_Result); end
      tests++; if (MEMWB_Regwrite !== 1'b1) begin fails++; $display("FAIL rw_first_rw: got %b want 1", MEMWB_Regwrite); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rw_req_after: got %b want 0", mem_req); end
      nop_inputs();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_ack_idle();
      test_branch();
      test_misaligned();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
